// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions, precision modes and the queued command record for the alu issue path.
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam int FLG_INV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;
  localparam logic MODE_SP = 1'b1;
  localparam logic MODE_HP = 1'b0;
  // Widest tag a sequencer instance may use; narrower tags are zero-extended into the record.
  localparam int TAG_MAX_W = 16;
  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0] op_code;
    logic mode_fp;
    logic round_mode;
    logic [TAG_MAX_W-1:0] tag;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with occupancy output; the owner never pushes when full or pops when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues alu commands, runs the level-held start/valid_out handshake one op at a time
// and returns tagged results through a single-entry response slot, with sticky flags and a watchdog.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [31:0] cmd_op_a,
  input  logic [31:0] cmd_op_b,
  input  logic [2:0] cmd_op_code,
  input  logic cmd_mode_fp,
  input  logic cmd_round_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  output logic [2:0] alu_op_code,
  output logic alu_mode_fp,
  output logic alu_round_mode,
  output logic alu_start,
  input  logic [31:0] alu_result,
  input  logic alu_valid_out,
  input  logic [4:0] alu_flags,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0] rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic rsp_timeout,
  output logic [4:0] sticky_flags,
  input  logic flags_clear,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DROP} state_t;
  state_t state, state_n;
  alu_cmd_t cmd_in, head, cur;
  logic [CW-1:0] cnt;
  logic push, pop, load, timed_out;
  logic [31:0] new_result;
  logic [4:0] new_flags;
  // Half-precision operands are cleaned on entry so the alu never sees stale upper bits.
  assign cmd_in = '{
    op_a: cmd_mode_fp == MODE_SP ? cmd_op_a : {16'h0, cmd_op_a[15:0]},
    op_b: cmd_mode_fp == MODE_SP ? cmd_op_b : {16'h0, cmd_op_b[15:0]},
    op_code: cmd_op_code,
    mode_fp: cmd_mode_fp,
    round_mode: cmd_round_mode,
    tag: TAG_MAX_W'(cmd_tag)
  };
  assign cmd_ready = fifo_level != LW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign alu_op_a = cur.op_a;
  assign alu_op_b = cur.op_b;
  assign alu_op_code = cur.op_code;
  assign alu_mode_fp = cur.mode_fp;
  assign alu_round_mode = cur.round_mode;
  alu_cmd_fifo #(.DEPTH(DEPTH), .W($bits(alu_cmd_t))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(cmd_in),
    .dout(head),
    .level(fifo_level)
  );
  // Issue only when the response slot is free or draining now, so a completion always has room.
  always_comb begin
    pop = state == IDLE && fifo_level != '0 && (!rsp_valid || rsp_ready);
    timed_out = state == ISSUE && !alu_valid_out && cnt == CW'(TIMEOUT - 1);
    load = (state == ISSUE && alu_valid_out) || timed_out;
    state_n = pop ? ISSUE : load ? WAIT_DROP : (state == WAIT_DROP && !alu_valid_out) ? IDLE : state;
    new_flags = timed_out ? 5'b10000 : alu_flags;
    new_result = timed_out ? 32'h0 : cur.mode_fp == MODE_SP ? alu_result : {16'h0, alu_result[15:0]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      alu_start <= 1'b0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_tag <= '0;
      rsp_timeout <= 1'b0;
      sticky_flags <= '0;
    end else begin
      state <= state_n;
      alu_start <= state_n == ISSUE;
      cnt <= state == ISSUE ? cnt + CW'(1) : '0;
      if (pop) cur <= head;
      if (load) begin
        rsp_valid <= 1'b1;
        rsp_result <= new_result;
        rsp_flags <= new_flags;
        rsp_tag <= TAG_W'(cur.tag);
        rsp_timeout <= timed_out;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      sticky_flags <= (flags_clear ? 5'h0 : sticky_flags) | (load ? new_flags : 5'h0);
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: drives the sequencer against a behavioural alu stub and checks responses,
// issued operands and sticky flags against a queue-based model of the command stream.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TIMEOUT = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_op_a = '0, cmd_op_b = '0;
  logic [2:0] cmd_op_code = '0;
  logic cmd_mode_fp = 1'b0, cmd_round_mode = 1'b0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [31:0] alu_op_a, alu_op_b;
  logic [2:0] alu_op_code;
  logic alu_mode_fp, alu_round_mode, alu_start;
  logic [31:0] alu_result = '0;
  logic alu_valid_out = 1'b0;
  logic [4:0] alu_flags = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [4:0] rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_timeout;
  logic [4:0] sticky_flags;
  logic flags_clear = 1'b0;
  logic [$clog2(DEPTH):0] fifo_level;
  int checks = 0, failures = 0;
  logic [41:0] exp_q[$];
  logic [68:0] iss_q[$];
  logic [4:0] sticky_m = '0;
  logic busy = 1'b0, hang = 1'b0;
  int lat = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
    .cmd_mode_fp(cmd_mode_fp), .cmd_round_mode(cmd_round_mode), .cmd_tag(cmd_tag),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .sticky_flags(sticky_flags), .flags_clear(flags_clear), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Stand-in alu arithmetic: arbitrary but deterministic, with upper bits set so HP masking is visible.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, b, input logic [2:0] op);
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000 ^ {29'h0, op};
  endfunction

  function automatic logic [4:0] flg_fn(input logic [31:0] a, b);
    return a[4:0] ^ b[9:5];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stub alu: level-held handshake, random latency, op code 7 never answers.
  always @(negedge clk) begin
    if (!alu_start) begin
      alu_valid_out = 1'b0;
      busy = 1'b0;
    end else if (!busy) begin
      logic [68:0] e;
      busy = 1'b1;
      hang = alu_op_code == 3'd7;
      lat = $urandom_range(0, 4);
      e = iss_q.size() != 0 ? iss_q.pop_front() : '1;
      chk("issue", {alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode}, e);
    end else if (!hang && !alu_valid_out) begin
      if (lat == 0) begin
        alu_valid_out = 1'b1;
        alu_result = alu_fn(alu_op_a, alu_op_b, alu_op_code);
        alu_flags = flg_fn(alu_op_a, alu_op_b);
      end else lat--;
    end
  end

  task automatic put(input logic [31:0] a, b, input logic [2:0] op, input logic m, r, input logic [3:0] t);
    logic [31:0] am, bm, res;
    am = m ? a : {16'h0, a[15:0]};
    bm = m ? b : {16'h0, b[15:0]};
    res = alu_fn(am, bm, op);
    if (!m) res[31:16] = 16'h0;
    cmd_op_a = a;
    cmd_op_b = b;
    cmd_op_code = op;
    cmd_mode_fp = m;
    cmd_round_mode = r;
    cmd_tag = t;
    iss_q.push_back({am, bm, op, m, r});
    exp_q.push_back(op == 3'd7 ? {32'h0, 5'b10000, t, 1'b1} : {res, flg_fn(am, bm), t, 1'b0});
  endtask

  task automatic send(input logic [31:0] a, b, input logic [2:0] op, input logic m, r, input logic [3:0] t);
    int w = 0;
    put(a, b, op, m, r, t);
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("send_wait", 128'(w >= 200), 128'(0));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int pct);
    logic [41:0] e;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      forever begin
        @(negedge clk);
        rsp_ready = $urandom_range(0, 99) < pct;
        w++;
        if ((rsp_valid && rsp_ready) || w > 400) break;
      end
      e = exp_q.size() != 0 ? exp_q.pop_front() : '1;
      chk("rsp", {rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_timeout}, {1'b1, e});
      sticky_m |= e[9:5];
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w, r;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {alu_start, rsp_valid, rsp_timeout, cmd_ready, fifo_level, sticky_flags}, {4'b0001, 3'd0, 5'd0});
    chk("rst_alu", {alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode}, 128'(0));
    chk("rst_rsp", {rsp_result, rsp_flags, rsp_tag}, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    // First-issue latency with an HP command carrying dirty upper operand bits.
    put(32'hDEAD_4000, 32'h1234_4000, OP_MUL, MODE_HP, 1'b1, 4'd3);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("lat_n", {alu_start, fifo_level}, {1'b0, 3'd1});
    @(negedge clk);
    chk("lat_n1", {alu_start, fifo_level, alu_op_a[31:16]}, {1'b1, 3'd0, 16'h0});
    drain(1, 100);
    // Random traffic with random backpressure and occasional hung operations.
    fork
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 7);
        send($urandom, $urandom, r == 7 ? 3'd7 : 3'(r & 3), 1'($urandom), 1'($urandom), 4'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(40, 60);
    join
    @(negedge clk);
    chk("rand_idle", {fifo_level, rsp_valid, alu_start}, 128'(0));
    chk("rand_sticky", sticky_flags, sticky_m);
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    chk("clr", sticky_flags, 128'(0));
    sticky_m = '0;
    send(32'h3F80_0001, 32'h0, OP_ADD, MODE_SP, 1'b0, 4'd5);
    drain(1, 100);
    chk("stk_x", sticky_flags, 5'b00001);
    // Clear coinciding with a response load keeps only the new flags.
    send(32'h0000_0004, 32'h0, OP_SUB, MODE_SP, 1'b0, 4'd6);
    w = 0;
    forever begin
      @(negedge clk);
      #1;
      w++;
      if ((alu_start && alu_valid_out) || w > 50) break;
    end
    chk("clr_wait", 128'(w > 50), 128'(0));
    flags_clear = 1'b1;
    @(posedge clk);
    #1 flags_clear = 1'b0;
    chk("clr_load", sticky_flags, 5'b00100);
    sticky_m = '0;
    @(negedge clk);
    drain(1, 100);
    // Backpressure: slot held, FIFO fills, drain returns everything in tag order.
    fork
      for (int i = 0; i < DEPTH + 2; i++) send(32'(i * 7), 32'(~i), OP_ADD, MODE_SP, 1'b0, 4'(i + 8));
      begin
        repeat (30) @(negedge clk);
        chk("bp_full", {cmd_ready, fifo_level, alu_start, rsp_valid}, {1'b0, 3'd4, 1'b0, 1'b1});
        drain(DEPTH + 2, 100);
      end
    join
    chk("bp_sticky", sticky_flags, sticky_m);
    // Reset while an operation hangs in ISSUE with another command queued.
    send(32'h1, 32'h2, 3'd7, MODE_SP, 1'b0, 4'd1);
    send(32'h3, 32'h4, OP_ADD, MODE_SP, 1'b0, 4'd2);
    chk("pre_rst", {alu_start, fifo_level, sticky_flags != 5'h0}, {1'b1, 3'd1, 1'b1});
    #3 rst = 1'b1;
    #1 chk("rst_async", {alu_start, fifo_level, sticky_flags, rsp_valid}, 128'(0));
    exp_q.delete();
    iss_q.delete();
    sticky_m = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(32'h4040_0000, 32'h4000_0000, OP_ADD, MODE_SP, 1'b0, 4'd3);
    drain(1, 100);
    chk("post_rst", {sticky_flags, fifo_level, alu_start}, {sticky_m, 3'd0, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
